sbinit_lane_seq: RTL and testbench

- Parametrised sideband-initialisation sequencer for the LTSM; successor to the single-lane SBINIT state.
- Supports N_LANES redundant sideband lanes. Drives the clock-pattern phase on all lanes, picks the first lane that shows a stable received pattern, then runs the out-of-reset / done request / done response message handshake on that lane.
- Sits between the LTSM top (enable, done, fail, timeout) and the SB serializer/deserializer and message encoder/decoder.

---
 rtl/sbinit_lane_seq_if.sv | 43 ++++
 rtl/sbinit_lane_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sbinit_lane_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sbinit_lane_seq_if.sv
// Signal bundle between the SBINIT lane sequencer and its surroundings
// (LTSM control, SB serializer/deserializer, message encoder/decoder).
// master: the sequencer. slave: the LTSM / sideband datapath side.
interface sbinit_lane_seq_if #(
    parameter int N_LANES = 2,
    parameter int MSG_W   = 8
);
    logic               enable_i;
    logic [N_LANES-1:0] pattern_det_i;
    logic               pattern_iter_done_i;
    logic               pattern_tx_en_o;
    logic [N_LANES-1:0] tx_lane_sel_o;
    logic [N_LANES-1:0] rx_lane_sel_o;
    logic [MSG_W-1:0]   TX_msg_o;
    logic               TX_msg_valid_o;
    logic               TX_msg_valid_ack_i;
    logic [MSG_W-1:0]   RX_msg_i;
    logic               RX_msg_req_o;
    logic               RX_msg_valid_i;
    logic               enable_SB_tx;
    logic               enable_SB_rx;
    logic               SBINIT_done_o;
    logic               SBINIT_fail_o;
    logic               reset_state_timeout_counter_o;

    modport master (
        input  enable_i, pattern_det_i, pattern_iter_done_i,
        input  TX_msg_valid_ack_i, RX_msg_i, RX_msg_valid_i,
        output pattern_tx_en_o, tx_lane_sel_o, rx_lane_sel_o,
        output TX_msg_o, TX_msg_valid_o, RX_msg_req_o,
        output enable_SB_tx, enable_SB_rx,
        output SBINIT_done_o, SBINIT_fail_o, reset_state_timeout_counter_o
    );

    modport slave (
        output enable_i, pattern_det_i, pattern_iter_done_i,
        output TX_msg_valid_ack_i, RX_msg_i, RX_msg_valid_i,
        input  pattern_tx_en_o, tx_lane_sel_o, rx_lane_sel_o,
        input  TX_msg_o, TX_msg_valid_o, RX_msg_req_o,
        input  enable_SB_tx, enable_SB_rx,
        input  SBINIT_done_o, SBINIT_fail_o, reset_state_timeout_counter_o
    );
endinterface

// File: rtl/sbinit_lane_seq.sv
// Multi-lane sideband initialisation sequencer: sends the clock pattern on
// all lanes, qualifies the lowest-index lane with a stable received pattern,
// then runs the OOR / DONE_REQ / DONE_RESP message exchange on that lane.
// Optional build macro SBINIT_RETRY_EN: the first timeout excludes the
// latched lane and restarts the pattern phase instead of failing.
//
// state   | meaning
// IDLE    | waiting for enable_i
// PATTERN | clock pattern on all lanes, qualifying an RX lane
// TAIL    | extra pattern iterations after qualification
// OOR_TX  | send out-of-reset message
// OOR_RX  | wait for partner out-of-reset message
// DREQ_TX | send done request
// DREQ_RX | wait for partner done request
// DRSP_TX | send done response
// DRSP_RX | wait for partner done response
// DONE    | sequence complete, held while enabled
// FAIL    | timed out, held while enabled
module sbinit_lane_seq #(
    parameter int N_LANES           = 2,
    parameter int MSG_W             = 8,
    parameter int PATTERN_ITER_MIN  = 2,
    parameter int PATTERN_TAIL_ITER = 4,
    parameter int TIMEOUT_CYC       = 800000,
    parameter int TMO_W             = 20
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    sbinit_lane_seq_if.master sb
);
    localparam int CNT_W  = $clog2(PATTERN_ITER_MIN + 1);
    localparam int TAIL_W = $clog2(PATTERN_TAIL_ITER + 1);

    localparam logic [MSG_W-1:0]   OP_OOR    = MSG_W'(1);
    localparam logic [MSG_W-1:0]   OP_DREQ   = MSG_W'(2);
    localparam logic [MSG_W-1:0]   OP_DRSP   = MSG_W'(3);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(PATTERN_ITER_MIN);
    localparam logic [TAIL_W-1:0]  TAIL_LAST = TAIL_W'(PATTERN_TAIL_ITER - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [N_LANES-1:0] ALL_LANES = '1;

    typedef enum logic [3:0] {
        IDLE, PATTERN, TAIL, OOR_TX, OOR_RX, DREQ_TX, DREQ_RX,
        DRSP_TX, DRSP_RX, DONE, FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TAIL_W-1:0]  tail_cnt;
    logic [CNT_W-1:0]   lane_cnt [N_LANES];
    logic [N_LANES-1:0] seen;
    logic [N_LANES-1:0] sel;
    logic [N_LANES-1:0] qual;
    logic [N_LANES-1:0] qual_low;
    logic [N_LANES-1:0] det_eff;
    logic               active;
    logic               tmo_hit;

    logic               pattern_tx_en;
    logic [N_LANES-1:0] tx_sel;
    logic [N_LANES-1:0] rx_sel;
    logic [MSG_W-1:0]   tx_msg;
    logic               tx_valid;
    logic               rx_req;
    logic               sb_en;
    logic               done;
    logic               fail;
    logic               start_pulse;

`ifdef SBINIT_RETRY_EN
    logic               retry_take;
    logic               retried;
    logic [N_LANES-1:0] excl;

    assign det_eff = sb.pattern_det_i & ~excl;
`else
    assign det_eff = sb.pattern_det_i;
`endif

    assign active   = (state != IDLE) && (state != DONE) && (state != FAIL);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    // Isolate the lowest set bit so the lowest-index qualifying lane wins.
    assign qual_low = qual & (~qual + N_LANES'(1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Lanes whose consecutive-iteration count reached the qualification level.
    always_comb begin
        qual = '0;
        for (int i = 0; i < N_LANES; i++) begin
            qual[i] = (lane_cnt[i] >= CNT_MAX);
        end
    end

    // State register.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; timeout and enable loss override the case.
    always_comb begin
        state_nxt     = state;
        pattern_tx_en = 1'b0;
        tx_sel        = '0;
        rx_sel        = '0;
        tx_msg        = '0;
        tx_valid      = 1'b0;
        rx_req        = 1'b0;
        sb_en         = 1'b0;
        done          = 1'b0;
        fail          = 1'b0;
        start_pulse   = 1'b0;
`ifdef SBINIT_RETRY_EN
        retry_take    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sb.enable_i) begin
                    state_nxt   = PATTERN;
                    start_pulse = 1'b1;
                end
            end
            PATTERN: begin
                pattern_tx_en = 1'b1;
                tx_sel        = ALL_LANES;
                rx_sel        = ALL_LANES;
                sb_en         = 1'b1;
                if (|qual) state_nxt = TAIL;
            end
            TAIL: begin
                pattern_tx_en = 1'b1;
                tx_sel        = ALL_LANES;
                rx_sel        = sel;
                sb_en         = 1'b1;
                if (sb.pattern_iter_done_i && (tail_cnt == TAIL_LAST)) state_nxt = OOR_TX;
            end
            OOR_TX, DREQ_TX, DRSP_TX: begin
                tx_sel   = sel;
                rx_sel   = sel;
                sb_en    = 1'b1;
                tx_valid = 1'b1;
                tx_msg   = (state == OOR_TX)  ? OP_OOR  :
                           (state == DREQ_TX) ? OP_DREQ : OP_DRSP;
                if (sb.TX_msg_valid_ack_i) begin
                    state_nxt = (state == OOR_TX)  ? OOR_RX  :
                                (state == DREQ_TX) ? DREQ_RX : DRSP_RX;
                end
            end
            OOR_RX, DREQ_RX, DRSP_RX: begin
                tx_sel = sel;
                rx_sel = sel;
                sb_en  = 1'b1;
                rx_req = 1'b1;
                if (sb.RX_msg_valid_i) begin
                    if ((state == OOR_RX) && (sb.RX_msg_i == OP_OOR))        state_nxt = DREQ_TX;
                    else if ((state == DREQ_RX) && (sb.RX_msg_i == OP_DREQ)) state_nxt = DRSP_TX;
                    else if ((state == DRSP_RX) && (sb.RX_msg_i == OP_DRSP)) state_nxt = DONE;
                end
            end
            DONE: begin
                tx_sel = sel;
                rx_sel = sel;
                sb_en  = 1'b1;
                done   = 1'b1;
            end
            FAIL: begin
                fail = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (active && tmo_hit) begin
`ifdef SBINIT_RETRY_EN
            if (!retried) begin
                state_nxt   = PATTERN;
                start_pulse = 1'b1;
                retry_take  = 1'b1;
            end else begin
                state_nxt = FAIL;
            end
`else
            state_nxt = FAIL;
`endif
        end

        if (!sb.enable_i) begin
            state_nxt   = IDLE;
            start_pulse = 1'b0;
`ifdef SBINIT_RETRY_EN
            retry_take  = 1'b0;
`endif
        end
    end

    // Timeout, lane qualification, tail and lane-select bookkeeping.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tmo_cnt  <= '0;
            tail_cnt <= '0;
            seen     <= '0;
            sel      <= '0;
            for (int i = 0; i < N_LANES; i++) lane_cnt[i] <= '0;
`ifdef SBINIT_RETRY_EN
            retried  <= 1'b0;
            excl     <= '0;
`endif
        end else if (!sb.enable_i || (state == IDLE)) begin
            tmo_cnt  <= '0;
            tail_cnt <= '0;
            seen     <= '0;
            sel      <= '0;
            for (int i = 0; i < N_LANES; i++) lane_cnt[i] <= '0;
`ifdef SBINIT_RETRY_EN
            retried  <= 1'b0;
            excl     <= '0;
`endif
        end else begin
            if (active && !tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state == PATTERN) begin
                // A detect coinciding with the iteration boundary still counts.
                for (int i = 0; i < N_LANES; i++) begin
                    if (sb.pattern_iter_done_i) begin
                        seen[i] <= 1'b0;
                        if (det_eff[i])   lane_cnt[i] <= sat_inc(lane_cnt[i]);
                        else if (!seen[i]) lane_cnt[i] <= '0;
                    end else if (det_eff[i]) begin
                        seen[i]     <= 1'b1;
                        lane_cnt[i] <= sat_inc(lane_cnt[i]);
                    end
                end
                if (|qual) sel <= qual_low;
            end else begin
                seen <= '0;
                for (int i = 0; i < N_LANES; i++) lane_cnt[i] <= '0;
            end

            if (state == TAIL) begin
                if (sb.pattern_iter_done_i) tail_cnt <= tail_cnt + TAIL_W'(1);
            end else begin
                tail_cnt <= '0;
            end

`ifdef SBINIT_RETRY_EN
            if (retry_take) begin
                tmo_cnt <= '0;
                retried <= 1'b1;
                excl    <= excl | sel;
                sel     <= '0;
            end
`endif
        end
    end

    assign sb.pattern_tx_en_o               = pattern_tx_en;
    assign sb.tx_lane_sel_o                 = tx_sel;
    assign sb.rx_lane_sel_o                 = rx_sel;
    assign sb.TX_msg_o                      = tx_msg;
    assign sb.TX_msg_valid_o                = tx_valid;
    assign sb.RX_msg_req_o                  = rx_req;
    assign sb.enable_SB_tx                  = sb_en;
    assign sb.enable_SB_rx                  = sb_en;
    assign sb.SBINIT_done_o                 = done;
    assign sb.SBINIT_fail_o                 = fail;
    assign sb.reset_state_timeout_counter_o = start_pulse;
endmodule

// File: tb/tb_sbinit_lane_seq.sv
// Bench for sbinit_lane_seq: directed and randomized lane-qualification
// episodes checked against a run-length lane model, message exchange,
// enable loss, asynchronous reset and timeout (with or without SBINIT_RETRY_EN).
module tb_sbinit_lane_seq;
    localparam int N    = 2;
    localparam int MW   = 8;
    localparam int MIN  = 2;
    localparam int TAIL = 4;
    localparam int TMO  = 100;
    localparam logic [N-1:0] ALL = '1;

    logic clk_100MHz = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    sbinit_lane_seq_if #(.N_LANES(N), .MSG_W(MW)) sb ();

    sbinit_lane_seq #(
        .N_LANES(N), .MSG_W(MW), .PATTERN_ITER_MIN(MIN),
        .PATTERN_TAIL_ITER(TAIL), .TIMEOUT_CYC(TMO), .TMO_W(8)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .sb(sb)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All outputs packed; bit1 = fail, bit2 = done, bit0 = start pulse.
    function automatic logic [31:0] outs_vec();
        return 32'({sb.pattern_tx_en_o, sb.tx_lane_sel_o, sb.rx_lane_sel_o,
                    sb.TX_msg_o, sb.TX_msg_valid_o, sb.RX_msg_req_o,
                    sb.enable_SB_tx, sb.enable_SB_rx, sb.SBINIT_done_o,
                    sb.SBINIT_fail_o, sb.reset_state_timeout_counter_o});
    endfunction

    function automatic logic [N-1:0] pick_mask(input int mode, input int it);
        if (mode == 1 && it < 2) return 2'b10;
        if (mode == 2 && it < 2) return 2'b11;
        if (mode == 3 && it < 4) return (it == 1) ? 2'b00 : 2'b01;
        if (it >= 6) return ALL;
        return N'($urandom_range(0, (1 << N) - 1));
    endfunction

    // One full enable episode. mode 0 = random, 1..3 = directed lane patterns.
    task automatic episode(input int mode, input bit abort_tx);
        int           run [N];
        bit           qual;
        bit           same;
        int           sel_l;
        int           it;
        int           dly;
        logic [N-1:0] m;
        logic [N-1:0] exp_sel;
        logic [MW-1:0] op;
        logic [MW-1:0] junk;

        for (int l = 0; l < N; l++) run[l] = 0;
        qual = 1'b0; sel_l = 0; it = 0; exp_sel = ALL;

        sb.enable_i = 1'b1;
        #1;
        chk("start_pulse", 32'(sb.reset_state_timeout_counter_o), 1);
        tick();
        chk("start_pulse_end", 32'(sb.reset_state_timeout_counter_o), 0);
        chk("pattern_en", 32'(sb.pattern_tx_en_o), 1);
        chk("pattern_masks", 32'({sb.tx_lane_sel_o, sb.rx_lane_sel_o}), 32'({ALL, ALL}));
        chk("pattern_sb_en", 32'({sb.enable_SB_tx, sb.enable_SB_rx}), 3);

        while (!qual) begin
            m    = pick_mask(mode, it);
            same = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            // Model: a lane qualifies after MIN consecutive iterations with a detect.
            for (int l = 0; l < N; l++) run[l] = m[l] ? run[l] + 1 : 0;
            for (int l = N - 1; l >= 0; l--) begin
                if (run[l] >= MIN) begin
                    qual  = 1'b1;
                    sel_l = l;
                end
            end
            sb.pattern_det_i       = m;
            sb.pattern_iter_done_i = same;
            tick();
            sb.pattern_det_i       = '0;
            sb.pattern_iter_done_i = 1'b0;
            tick();
            exp_sel = qual ? (N'(1) << sel_l) : ALL;
            chk("lane_rx_mask", 32'(sb.rx_lane_sel_o), 32'(exp_sel));
            chk("lane_tx_mask", 32'(sb.tx_lane_sel_o), 32'(ALL));
            if (!qual && !same) begin
                sb.pattern_iter_done_i = 1'b1;
                tick();
                sb.pattern_iter_done_i = 1'b0;
            end
            it++;
        end

        if (mode == 1) chk("dir_lane1", 32'(sb.rx_lane_sel_o), 2);
        if (mode == 2) chk("dir_lane0_tie", 32'(sb.rx_lane_sel_o), 1);
        if (mode == 3) chk("dir_missed_iter", 32'(it), 4);

        for (int k = 0; k < TAIL; k++) begin
            chk("tail_pattern_en", 32'(sb.pattern_tx_en_o), 1);
            chk("tail_tx_mask", 32'(sb.tx_lane_sel_o), 32'(ALL));
            sb.pattern_iter_done_i = 1'b1;
            tick();
            sb.pattern_iter_done_i = 1'b0;
            tick();
        end

        chk("oor_pattern_off", 32'(sb.pattern_tx_en_o), 0);
        chk("oor_masks", 32'({sb.tx_lane_sel_o, sb.rx_lane_sel_o}), 32'({exp_sel, exp_sel}));
        chk("oor_valid", 32'(sb.TX_msg_valid_o), 1);

        if (abort_tx) begin
            sb.enable_i = 1'b0;
            tick();
            chk("abort_outs", outs_vec(), 0);
            return;
        end

        for (int s = 0; s < 3; s++) begin
            op  = MW'(s + 1);
            dly = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
            for (int d = 0; d <= dly; d++) begin
                chk("tx_valid", 32'(sb.TX_msg_valid_o), 1);
                chk("tx_opcode", 32'(sb.TX_msg_o), 32'(op));
                if (d < dly) tick();
            end
            sb.TX_msg_valid_ack_i = 1'b1;
            tick();
            sb.TX_msg_valid_ack_i = 1'b0;
            chk("tx_valid_drop", 32'(sb.TX_msg_valid_o), 0);
            chk("rx_req", 32'(sb.RX_msg_req_o), 1);
            if (mode != 0 || $urandom_range(0, 1) == 1) begin
                if (mode != 0) junk = (op == 3) ? MW'(1) : op + MW'(1);
                else begin
                    junk = MW'($urandom_range(0, 255));
                    if (junk == op) junk = op ^ MW'(8'h80);
                end
                sb.RX_msg_i       = junk;
                sb.RX_msg_valid_i = 1'b1;
                tick();
                sb.RX_msg_valid_i = 1'b0;
                chk("rx_junk_stay", 32'(sb.RX_msg_req_o), 1);
                chk("rx_junk_no_tx", 32'(sb.TX_msg_valid_o), 0);
            end
            sb.RX_msg_i       = op;
            sb.RX_msg_valid_i = 1'b1;
            tick();
            sb.RX_msg_valid_i = 1'b0;
            chk("rx_accept", 32'(sb.RX_msg_req_o), 0);
        end

        chk("done", 32'(sb.SBINIT_done_o), 1);
        chk("done_masks", 32'({sb.tx_lane_sel_o, sb.rx_lane_sel_o}), 32'({exp_sel, exp_sel}));
        chk("done_sb_en", 32'({sb.enable_SB_tx, sb.enable_SB_rx}), 3);
        tick();
        chk("done_hold", 32'(sb.SBINIT_done_o), 1);
        sb.enable_i = 1'b0;
        tick();
        chk("disable_outs", outs_vec(), 0);
    endtask

    initial begin
        reset                  = 1'b1;
        sb.enable_i            = 1'b0;
        sb.pattern_det_i       = '0;
        sb.pattern_iter_done_i = 1'b0;
        sb.TX_msg_valid_ack_i  = 1'b0;
        sb.RX_msg_i            = '0;
        sb.RX_msg_valid_i      = 1'b0;
        tick();
        tick();
        chk("reset_outs", outs_vec(), 0);
        reset = 1'b0;
        tick();
        chk("idle_outs", outs_vec(), 0);

        episode(1, 1'b0);
        episode(2, 1'b0);
        episode(3, 1'b0);
        episode(0, 1'b1);
        for (int e = 0; e < 8; e++) episode(0, 1'b0);

        // Asynchronous reset in the middle of the pattern phase.
        sb.enable_i = 1'b1;
        tick();
        tick();
        chk("pre_reset_pattern", 32'(sb.pattern_tx_en_o), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_masks", 32'({sb.pattern_tx_en_o, sb.tx_lane_sel_o, sb.rx_lane_sel_o}), 0);
        sb.enable_i = 1'b0;
        #1;
        chk("async_reset_outs", outs_vec(), 0);
        #1 reset = 1'b0;
        tick();

        // Timeout with no pattern ever received.
        sb.enable_i = 1'b1;
        tick();
        for (int c = 1; c < TMO; c++) tick();
        chk("tmo_pre_fail", 32'(sb.SBINIT_fail_o), 0);
`ifdef SBINIT_RETRY_EN
        chk("tmo_retry_pulse", 32'(sb.reset_state_timeout_counter_o), 1);
        tick();
        chk("tmo_retry_nofail", 32'(sb.SBINIT_fail_o), 0);
        chk("tmo_retry_pattern", 32'(sb.pattern_tx_en_o), 1);
        for (int c = 1; c < TMO; c++) tick();
        chk("tmo2_pre_fail", 32'(sb.SBINIT_fail_o), 0);
        chk("tmo2_no_pulse", 32'(sb.reset_state_timeout_counter_o), 0);
        tick();
`else
        chk("tmo_no_pulse", 32'(sb.reset_state_timeout_counter_o), 0);
        tick();
`endif
        chk("tmo_fail", 32'(sb.SBINIT_fail_o), 1);
        chk("fail_outs", outs_vec(), 2);
        tick();
        chk("fail_hold", outs_vec(), 2);
        sb.enable_i = 1'b0;
        tick();
        chk("fail_release", outs_vec(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
